lockstep_compare_monitor: RTL and testbench

LOCKSTEP_COMPARE_MONITOR -- requirements
Module: lockstep_compare_monitor

---
 rtl/lockstep_compare_monitor.sv | 164 ++++++++++++++++
 tb/tb_lockstep_compare_monitor.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lockstep_compare_monitor.sv
// rtl/lockstep_compare_monitor.sv - lockstep reference/device output comparator with pass/fail verdict
//
// Parameters:
//   WIDTH        compared bus width (1..64)
//   LAG          cycles by which dut_d trails ref_d (0..7)
//   CNT_W        width of sample_cnt, mismatch_cnt and first_idx
//   STOP_ON_FAIL when nonzero the first mismatch ends the run in FAIL
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start, stop, clr        run control (priority clr > start > stop)
//   valid, ref_d, dut_d     compared streams; ref_d/valid are delayed by LAG
//   state, done, err        verdict state (IDLE/RUN/PASS/FAIL), done, sticky error
//   sample_cnt, mismatch_cnt saturating counters
//   first_idx/ref/dut       capture of the first mismatch of the run
module lockstep_compare_monitor #(
    parameter int WIDTH        = 8,
    parameter int LAG          = 1,
    parameter int CNT_W        = 16,
    parameter int STOP_ON_FAIL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             clr,
    input  logic             valid,
    input  logic [WIDTH-1:0] ref_d,
    input  logic [WIDTH-1:0] dut_d,
    output logic [1:0]       state,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] first_idx,
    output logic [WIDTH-1:0] first_ref,
    output logic [WIDTH-1:0] first_dut
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_PASS = 2'b10,
        S_FAIL = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           st;
    state_t           nxt;
    logic             arm;
    logic             flush;
    logic             run;
    logic             d_val;
    logic [WIDTH-1:0] d_ref;
    logic             smp;
    logic             mis;

    assign arm   = (st == S_IDLE) && start;
    assign flush = clr || arm;
    assign run   = (st == S_RUN) && !clr;

    // Delay line for valid/ref_d. It only moves while running and is
    // emptied whenever a run is armed or cleared, so stale data from a
    // previous run can never form a sample.
    generate
        if (LAG == 0) begin : g_nodly
            assign d_val = valid;
            assign d_ref = ref_d;
        end else begin : g_dly
            logic             sr_val [LAG];
            logic [WIDTH-1:0] sr_ref [LAG];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < LAG; i++) begin
                        sr_val[i] <= 1'b0;
                        sr_ref[i] <= '0;
                    end
                end else if (flush) begin
                    for (int i = 0; i < LAG; i++) begin
                        sr_val[i] <= 1'b0;
                        sr_ref[i] <= '0;
                    end
                end else if (run) begin
                    for (int i = LAG - 1; i > 0; i--) begin
                        sr_val[i] <= sr_val[i-1];
                        sr_ref[i] <= sr_ref[i-1];
                    end
                    sr_val[0] <= valid;
                    sr_ref[0] <= ref_d;
                end
            end

            assign d_val = sr_val[LAG-1];
            assign d_ref = sr_ref[LAG-1];
        end
    endgenerate

    // Case-inequality so X/Z on either side is flagged in simulation.
    assign smp = (st == S_RUN) && d_val && valid;
    assign mis = smp && (d_ref !== dut_d);

    always_comb begin
        nxt = st;
        if (clr) begin
            nxt = S_IDLE;
        end else begin
            case (st)
                S_IDLE: if (start) nxt = S_RUN;
                S_RUN: begin
                    // err is registered, so a mismatch in the stop cycle
                    // itself is folded in through mis.
                    if (stop)
                        nxt = (err || mis) ? S_FAIL : S_PASS;
                    else if ((STOP_ON_FAIL != 0) && mis)
                        nxt = S_FAIL;
                end
                default: nxt = st;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st   <= S_IDLE;
            done <= 1'b0;
        end else begin
            st   <= nxt;
            done <= (nxt == S_PASS) || (nxt == S_FAIL);
        end
    end

    assign state = st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err          <= 1'b0;
            sample_cnt   <= '0;
            mismatch_cnt <= '0;
            first_idx    <= '0;
            first_ref    <= '0;
            first_dut    <= '0;
        end else if (flush) begin
            err          <= 1'b0;
            sample_cnt   <= '0;
            mismatch_cnt <= '0;
            first_idx    <= '0;
            first_ref    <= '0;
            first_dut    <= '0;
        end else if (st == S_RUN) begin
            if (smp && (sample_cnt != CNT_MAX))
                sample_cnt <= sample_cnt + 1'b1;
            if (mis && (mismatch_cnt != CNT_MAX))
                mismatch_cnt <= mismatch_cnt + 1'b1;
            if (mis && !err) begin
                err       <= 1'b1;
                first_idx <= sample_cnt;
                first_ref <= d_ref;
                first_dut <= dut_d;
            end
        end
    end

endmodule

// File: tb/tb_lockstep_compare_monitor.sv
// tb/tb_lockstep_compare_monitor.sv - randomized self-checking bench for lockstep_compare_monitor
module tb_lockstep_compare_monitor;

    localparam int NI = 4;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       clr;
    logic       valid;
    logic [7:0] ref_d;
    logic [7:0] dut_d;

    logic [1:0]  o_st   [NI];
    logic        o_done [NI];
    logic        o_err  [NI];
    logic [15:0] o_sc   [NI];
    logic [15:0] o_mc   [NI];
    logic [15:0] o_fi   [NI];
    logic [7:0]  o_fr   [NI];
    logic [7:0]  o_fd   [NI];
    logic [3:0]  s2_sc;
    logic [3:0]  s2_mc;
    logic [3:0]  s2_fi;

    // Instance settings: LAG, STOP_ON_FAIL, counter ceiling
    int lagv [NI] = '{1, 1, 1, 3};
    int sofv [NI] = '{0, 1, 0, 0};
    int cmax [NI] = '{65535, 65535, 15, 65535};

    lockstep_compare_monitor #(.WIDTH(8), .LAG(1), .CNT_W(16), .STOP_ON_FAIL(0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clr(clr), .valid(valid),
        .ref_d(ref_d), .dut_d(dut_d), .state(o_st[0]), .done(o_done[0]), .err(o_err[0]),
        .sample_cnt(o_sc[0]), .mismatch_cnt(o_mc[0]), .first_idx(o_fi[0]),
        .first_ref(o_fr[0]), .first_dut(o_fd[0]));

    lockstep_compare_monitor #(.WIDTH(8), .LAG(1), .CNT_W(16), .STOP_ON_FAIL(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clr(clr), .valid(valid),
        .ref_d(ref_d), .dut_d(dut_d), .state(o_st[1]), .done(o_done[1]), .err(o_err[1]),
        .sample_cnt(o_sc[1]), .mismatch_cnt(o_mc[1]), .first_idx(o_fi[1]),
        .first_ref(o_fr[1]), .first_dut(o_fd[1]));

    lockstep_compare_monitor #(.WIDTH(8), .LAG(1), .CNT_W(4), .STOP_ON_FAIL(0)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clr(clr), .valid(valid),
        .ref_d(ref_d), .dut_d(dut_d), .state(o_st[2]), .done(o_done[2]), .err(o_err[2]),
        .sample_cnt(s2_sc), .mismatch_cnt(s2_mc), .first_idx(s2_fi),
        .first_ref(o_fr[2]), .first_dut(o_fd[2]));

    lockstep_compare_monitor #(.WIDTH(8), .LAG(3), .CNT_W(16), .STOP_ON_FAIL(0)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clr(clr), .valid(valid),
        .ref_d(ref_d), .dut_d(dut_d), .state(o_st[3]), .done(o_done[3]), .err(o_err[3]),
        .sample_cnt(o_sc[3]), .mismatch_cnt(o_mc[3]), .first_idx(o_fi[3]),
        .first_ref(o_fr[3]), .first_dut(o_fd[3]));

    assign o_sc[2] = {12'd0, s2_sc};
    assign o_mc[2] = {12'd0, s2_mc};
    assign o_fi[2] = {12'd0, s2_fi};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: a log of every cycle's inputs; the delayed side of
    // a comparison is simply the logged input LAG cycles back within the run.
    int         m_st  [NI];
    logic       m_err [NI];
    int         m_sc  [NI];
    int         m_mc  [NI];
    int         m_fi  [NI];
    logic [7:0] m_fr  [NI];
    logic [7:0] m_fd  [NI];
    int         m_k   [NI];
    logic       lv    [4096];
    logic [7:0] lr    [4096];
    int         cyc = 0;

    task automatic model_clear(input int i);
        m_st[i] = 0; m_err[i] = 1'b0; m_sc[i] = 0; m_mc[i] = 0;
        m_fi[i] = 0; m_fr[i] = 8'h00; m_fd[i] = 8'h00; m_k[i] = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) model_clear(i);
    endtask

    task automatic model_step();
        logic       dv;
        logic [7:0] dr;
        logic       smp;
        logic       mis;
        lv[cyc % 4096] = valid;
        lr[cyc % 4096] = ref_d;
        for (int i = 0; i < NI; i++) begin
            if (clr) begin
                model_clear(i);
            end else if (m_st[i] == 0) begin
                if (start) begin
                    model_clear(i);
                    m_st[i] = 1;
                end
            end else if (m_st[i] == 1) begin
                if (lagv[i] == 0) begin
                    dv = valid; dr = ref_d;
                end else if (m_k[i] >= lagv[i]) begin
                    dv = lv[(cyc - lagv[i]) % 4096]; dr = lr[(cyc - lagv[i]) % 4096];
                end else begin
                    dv = 1'b0; dr = 8'h00;
                end
                smp = dv && valid;
                mis = smp && (dr !== dut_d);
                if (mis && !m_err[i]) begin
                    m_err[i] = 1'b1; m_fi[i] = m_sc[i]; m_fr[i] = dr; m_fd[i] = dut_d;
                end
                if (smp && m_sc[i] < cmax[i]) m_sc[i]++;
                if (mis && m_mc[i] < cmax[i]) m_mc[i]++;
                m_k[i]++;
                if (stop) m_st[i] = m_err[i] ? 3 : 2;
                else if (sofv[i] != 0 && mis) m_st[i] = 3;
            end
        end
        cyc++;
    endtask

    always @(posedge clk) if (rst_n) model_step();
    always @(negedge rst_n) model_reset();

    task automatic compare_all();
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("u%0d.state", i), 64'(o_st[i]), 64'(m_st[i]));
            chk($sformatf("u%0d.done", i), 64'(o_done[i]), 64'(m_st[i] >= 2));
            chk($sformatf("u%0d.err", i), 64'(o_err[i]), 64'(m_err[i]));
            chk($sformatf("u%0d.sample_cnt", i), 64'(o_sc[i]), 64'(m_sc[i]));
            chk($sformatf("u%0d.mismatch_cnt", i), 64'(o_mc[i]), 64'(m_mc[i]));
            chk($sformatf("u%0d.first_idx", i), 64'(o_fi[i]), 64'(m_fi[i]));
            chk($sformatf("u%0d.first_ref", i), 64'(o_fr[i]), 64'(m_fr[i]));
            chk($sformatf("u%0d.first_dut", i), 64'(o_fd[i]), 64'(m_fd[i]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        start = 1'b0; stop = 1'b0; clr = 1'b0;
        compare_all();
    endtask

    logic [7:0] prev = 8'h00;
    int         rc   = 0;

    task automatic begin_run();
        start = 1'b1; valid = 1'b0;
        step();
        rc = 0;
    endtask

    task automatic end_run();
        stop = 1'b1; valid = 1'b0;
        step();
    endtask

    task automatic do_clr();
        clr = 1'b1; valid = 1'b0;
        step();
    endtask

    // kind: 0 clean, 1 flip bit 0 on sample fidx, 2 X on sample fidx, 3 invert every sample.
    // With continuous valid and LAG=1, run cycle rc carries sample rc-1.
    task automatic stream(input int n, input int fidx, input int kind);
        logic [7:0] r;
        logic [7:0] d;
        int         s;
        for (int c = 0; c < n; c++) begin
            s = rc - 1;
            r = 8'($urandom);
            if (kind == 2 && rc == fidx) r = 8'h5A;
            d = (rc == 0) ? 8'($urandom) : prev;
            if (kind == 1 && s == fidx) d = d ^ 8'h01;
            if (kind == 3 && s >= 0) d = ~d;
            valid = 1'b1;
            ref_d = r;
            dut_d = d;
            if (kind == 2 && s == fidx) dut_d = 'x;
            prev = r;
            step();
            rc++;
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; clr = 1'b0;
        valid = 1'b0; ref_d = 8'h00; dut_d = 8'h00;
        model_reset();
        repeat (3) step();
        chk("reset.state", 64'(o_st[0]), 64'd0);
        chk("reset.done", 64'(o_done[0]), 64'd0);
        chk("reset.sample_cnt", 64'(o_sc[0]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // clean run
        begin_run();
        stream(100, -1, 0);
        end_run();
        chk("clean.state", 64'(o_st[0]), 64'd2);
        chk("clean.sample_cnt", 64'(o_sc[0]), 64'd99);
        chk("clean.mismatch_cnt", 64'(o_mc[0]), 64'd0);
        chk("clean.err", 64'(o_err[0]), 64'd0);
        start = 1'b1; stop = 1'b1; valid = 1'b1;
        step();
        chk("pass.hold", 64'(o_st[0]), 64'd2);
        do_clr();

        // single fault on sample 10
        begin_run();
        stream(100, 10, 1);
        end_run();
        chk("fault.state", 64'(o_st[0]), 64'd3);
        chk("fault.mismatch_cnt", 64'(o_mc[0]), 64'd1);
        chk("fault.first_idx", 64'(o_fi[0]), 64'd10);
        chk("fault.xor", 64'(o_fr[0] ^ o_fd[0]), 64'h01);
        do_clr();

        // X on sample 3
        begin_run();
        stream(5, 3, 2);
        chk("xval.err", 64'(o_err[0]), 64'd1);
        chk("xval.first_idx", 64'(o_fi[0]), 64'd3);
        stream(5, -1, 0);
        end_run();
        do_clr();

        // fail-fast on sample 5
        begin_run();
        stream(7, 5, 1);
        chk("ff.state", 64'(o_st[1]), 64'd3);
        chk("ff.sample_cnt", 64'(o_sc[1]), 64'd6);
        stream(5, -1, 0);
        chk("ff.sample_cnt_frozen", 64'(o_sc[1]), 64'd6);
        end_run();
        do_clr();

        // saturation, 20+ mismatches on 4-bit counters
        begin_run();
        stream(22, -1, 3);
        chk("sat.mismatch_cnt", 64'(o_mc[2]), 64'd15);
        end_run();
        do_clr();

        // simultaneous controls
        begin_run();
        stream(4, -1, 0);
        start = 1'b1; stop = 1'b1; clr = 1'b1; valid = 1'b1;
        step();
        chk("ctl.clr_wins", 64'(o_st[0]), 64'd0);
        chk("ctl.clr_cnt", 64'(o_sc[0]), 64'd0);
        start = 1'b1; stop = 1'b1; valid = 1'b0;
        step();
        rc = 0;
        chk("ctl.start_wins", 64'(o_st[0]), 64'd1);

        // reset mid-run
        stream(6, -1, 0);
        rst_n = 1'b0;
        #1;
        chk("rst.async_state", 64'(o_st[0]), 64'd0);
        chk("rst.async_cnt", 64'(o_sc[0]), 64'd0);
        repeat (3) step();
        rst_n = 1'b1;
        stop = 1'b1; valid = 1'b1;
        step();
        valid = 1'b1;
        step();
        chk("rst.stay_idle", 64'(o_st[0]), 64'd0);

        // random control and data against the model
        for (int c = 0; c < 600; c++) begin
            start = ($urandom_range(0, 19) == 0);
            stop  = ($urandom_range(0, 29) == 0);
            clr   = ($urandom_range(0, 59) == 0);
            valid = ($urandom_range(0, 3) != 0);
            ref_d = 8'($urandom);
            dut_d = ($urandom_range(0, 15) == 0) ? 8'($urandom) : prev;
            prev  = ref_d;
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
